// File: rtl/accum_uart_tx.sv
// accum_uart_tx: watches the accumulator bus and queues every new value in a
// small circular FIFO. The queued bytes are sent on a UART line as 8N1 frames,
// LSB first.
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   ACC_IN     accumulator value to watch
//   TX         UART serial line, idle high (registered)
//   TX_BUSY    high while a frame is on the line (registered)
//   FIFO_COUNT number of queued bytes, 0..FIFO_DEPTH
//   OVERFLOW   sticky flag, set when a change was dropped because the FIFO was full
module accum_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [7:0]                    ACC_IN,
  output logic                          TX,
  output logic                          TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERFLOW
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [7:0]         last;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CLK_W-1:0]   clk_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;

  // A pop on the same edge frees the slot, so a push into a full FIFO still succeeds then.
  always_comb begin
    push_req = (ACC_IN != last);
    pop      = (state == IDLE) && (FIFO_COUNT != '0);
    full     = (FIFO_COUNT == FULL_CNT);
    push_ok  = push_req && (!full || pop);
  end

  // Change capture, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last       <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_COUNT <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (push_req) last <= ACC_IN;
      if (push_req && !push_ok) OVERFLOW <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop) FIFO_COUNT <= FIFO_COUNT + CNT_W'(1);
      else if (!push_ok && pop) FIFO_COUNT <= FIFO_COUNT - CNT_W'(1);
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= ACC_IN;
  end

  // Serialiser: TX is updated on the edge that enters each bit so it stays registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= 8'h00;
      TX      <= 1'b1;
      TX_BUSY <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          TX      <= 1'b1;
          TX_BUSY <= 1'b0;
          if (pop) begin
            shift   <= mem[rd_ptr];
            bit_cnt <= '0;
            clk_cnt <= '0;
            TX      <= 1'b0;
            TX_BUSY <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            TX      <= shift[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              TX    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              TX      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        STOP: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            TX_BUSY <= 1'b0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/accum_uart_tx.md
Name: accum_uart_tx

Overview:
Downstream output stage of the CPU. It watches the 8-bit accumulator bus ACCUM_OUT and enqueues every new value into a small FIFO. It serialises the queued bytes on a single UART line (8N1, LSB first). This gives the CPU an externally observable result stream without any extra control signal from CONTROL.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per UART bit (>=2)
FIFO_DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
CLK  input  1  single system clock, rising edge
RST  input  1  asynchronous, active-high reset
ACC_IN  input  8  accumulator value (connect to ACCUM_OUT)
TX  output  1  UART serial line, idle high
TX_BUSY  output  1  high while a frame is on the line
FIFO_COUNT  output  log2(FIFO_DEPTH)+1  number of queued bytes
OVERFLOW  output  1  sticky; a value was lost because the FIFO was full

Behaviour:
- Clocking and reset:
  - One clock (CLK). Reset RST is asynchronous, active-high.
  - While RST is high: TX=1, TX_BUSY=0, FIFO_COUNT=0, OVERFLOW=0, LAST=8'h00, FSM=IDLE.
  - Reset mid-frame aborts the frame immediately. TX returns high asynchronously and FIFO contents are discarded.
- Change capture:
  - Internal register LAST holds the last value seen.
  - On each CLK edge where ACC_IN != LAST: LAST<=ACC_IN and a push of ACC_IN is requested.
  - A value equal to LAST is never enqueued. After reset, an ACC_IN of 8'h00 is therefore not enqueued.
  - Push when not full: the entry is written and FIFO_COUNT increments on that edge.
  - Push when full with no pop that cycle: the value is dropped, OVERFLOW<=1, and LAST still updates.
  - OVERFLOW is cleared only by RST.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge: both succeed and the count is unchanged. This holds when full (the pop frees the slot) and otherwise.
  - Pop while empty never occurs; the FSM only pops when FIFO_COUNT != 0.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: TX=1, TX_BUSY=0. If FIFO_COUNT != 0 on an edge: pop the head into the 8-bit shift register, go to START, and clear the bit counter. TX falls on that same edge (one cycle after the byte becomes visible).
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: TX=shift[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After 8 bits, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - TX_BUSY=1 in START, DATA and STOP.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - The next frame may start one cycle after returning to IDLE (one idle-high cycle minimum between frames).
- Other requirements:
  - TX and TX_BUSY are registered outputs, with no combinational path from ACC_IN.
  - A width mismatch is not permitted; the FIFO_COUNT width is log2(FIFO_DEPTH)+1 so that FIFO_DEPTH itself is representable.

Test Plan:
- Reset: hold RST across 3 edges, then assert RST mid-DATA of a frame → TX=1 immediately; TX_BUSY=0, FIFO_COUNT=0, OVERFLOW=0; no further TX edges until a new ACC_IN change.
- Single byte, CLKS_PER_BIT=4: ACC_IN 00→A5 and held →
  - FIFO_COUNT=1 for one cycle;
  - TX low for 4 cycles;
  - then bits 1,0,1,0,0,1,0,1 at 4 cycles each;
  - then high for 4 cycles;
  - total 40 cycles.
- No-change filter: ACC_IN held at 3C for 200 cycles, then 3C→3C→00 → exactly two frames (3C, 00).
- Overflow, FIFO_DEPTH=4: ACC_IN changes every cycle 01,02,…,07 while the first frame is sending →
  - bytes 01..05 are transmitted (01 is popped immediately, 02..05 fill the FIFO);
  - 06 and 07 are dropped and OVERFLOW=1 stays set after the FIFO drains;
  - FIFO_COUNT never exceeds 4.
- Full push+pop: fill the FIFO to 4 and present a new ACC_IN on the exact edge the FSM pops → FIFO_COUNT stays 4, OVERFLOW stays 0, and the new byte is transmitted last.
- Back-to-back frames: queue 81 and 7E → second start bit begins exactly 1 idle cycle after the first stop bit ends; pointers wrap correctly after more than FIFO_DEPTH total bytes.
